ext_bus_responder: RTL

Peripheral-side responder for the external-bus port of `nios_system`, on the far side of its Avalon-to-external-bus bridge. It decodes bridge transactions, serves a 256-word on-chip RAM and a small register bank, and returns `acknowledge` with read data after a configurable wait. The register bank drives the board LEDs and a 16-bit interval timer; the timer raises the bridge `irq` when it expires.

---
 rtl/ext_bus_pkg.sv | 22 ++
 rtl/ext_bus_timer.sv | 47 ++++
 rtl/ext_bus_responder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ext_bus_pkg.sv
// Shared definitions for the external-bus responder: register map, TCTRL bit
// positions and the bus handshake states.
package ext_bus_pkg;

  localparam logic [10:0] LED_ADDR    = 11'h400;
  localparam logic [10:0] TLOAD_ADDR  = 11'h402;
  localparam logic [10:0] TCTRL_ADDR  = 11'h404;
  localparam logic [10:0] TSTAT_ADDR  = 11'h406;
  localparam logic [10:0] TCOUNT_ADDR = 11'h408;

  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_IE   = 1;
  localparam int TCTRL_AUTO = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_RECOVER
  } bus_state_e;

endpackage

// File: rtl/ext_bus_timer.sv
// 16-bit interval timer: down counter with one-shot or auto-reload expiry,
// sticky EXP flag and a registered interrupt.
module ext_bus_timer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tctrl_wr,
  input  logic              en_wdata,
  input  logic              exp_clr,
  input  logic              ie,
  input  logic              auto_reload,
  input  logic [DATA_W-1:0] tload,
  output logic [DATA_W-1:0] tcount,
  output logic              exp_flag,
  output logic              en,
  output logic              irq
);

  logic expire;
  logic en_rise;

  assign expire  = en && (tcount == '0);
  assign en_rise = tctrl_wr && en_wdata && !en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcount   <= '0;
      exp_flag <= 1'b0;
      en       <= 1'b0;
      irq      <= 1'b0;
    end else begin
      // One-shot expiry wins over a simultaneous EN write; otherwise the write lands.
      if (expire && !auto_reload) en <= 1'b0;
      else if (tctrl_wr)          en <= en_wdata;

      if (en_rise || (expire && auto_reload)) tcount <= tload;
      else if (en && (tcount != '0))          tcount <= tcount - 1'b1;

      if (expire)       exp_flag <= 1'b1;
      else if (exp_clr) exp_flag <= 1'b0;

      irq <= exp_flag && ie;
    end
  end

endmodule

// File: rtl/ext_bus_responder.sv
// Bridge-side responder: decodes external-bus transactions, serves a 256x16
// RAM plus LED/timer registers, and acknowledges after WAIT_CYCLES wait states.
module ext_bus_responder
  import ext_bus_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              bus_enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [1:0]        byte_enable,
  input  logic              rw,
  input  logic [DATA_W-1:0] write_data,
  output logic              acknowledge,
  output logic [DATA_W-1:0] read_data,
  output logic              irq,
  output logic [9:0]        ledr
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  bus_state_e        state, state_next;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [1:0]        be_q;
  logic [DATA_W-1:0] wdata_q;

  logic [9:0]        led;
  logic [DATA_W-1:0] tload;
  logic              ie, auto_reload;
  logic [DATA_W-1:0] tcount;
  logic              exp_flag, en;

  logic [DATA_W-1:0] ram [256];
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] word_addr;
  logic [7:0]        ram_idx;
  logic              ram_hit, start, commit;
  logic              tctrl_wr, exp_clr;

  assign start     = (state == ST_IDLE) && bus_enable;
  assign commit    = (state == ST_ACK) && !rw_q;
  assign word_addr = addr_q & ~ADDR_W'(1);
  assign ram_hit   = (word_addr[ADDR_W-1:ADDR_W-2] == 2'b00);
  assign ram_idx   = word_addr[8:1];
  assign tctrl_wr  = commit && (word_addr == ADDR_W'(TCTRL_ADDR)) && be_q[0];
  assign exp_clr   = commit && (word_addr == ADDR_W'(TSTAT_ADDR)) && be_q[0] && wdata_q[0];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= ST_IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (bus_enable) state_next = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
      ST_WAIT:    if (wait_cnt == 4'd0) state_next = ST_ACK;
      ST_ACK:     state_next = ST_RECOVER;
      ST_RECOVER: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      be_q     <= 2'b00;
      wdata_q  <= '0;
    end else if (start) begin
      wait_cnt <= WAIT_LOAD;
      addr_q   <= address;
      rw_q     <= rw;
      be_q     <= byte_enable;
      wdata_q  <= write_data;
    end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Register bank; writes land on the edge that ends the ACK cycle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      led         <= '0;
      tload       <= '0;
      ie          <= 1'b0;
      auto_reload <= 1'b0;
    end else if (commit) begin
      if (word_addr == ADDR_W'(LED_ADDR)) begin
        if (be_q[0]) led[7:0] <= wdata_q[7:0];
        if (be_q[1]) led[9:8] <= wdata_q[9:8];
      end
      if (word_addr == ADDR_W'(TLOAD_ADDR)) begin
        if (be_q[0]) tload[7:0]        <= wdata_q[7:0];
        if (be_q[1]) tload[DATA_W-1:8] <= wdata_q[DATA_W-1:8];
      end
      if ((word_addr == ADDR_W'(TCTRL_ADDR)) && be_q[0]) begin
        ie          <= wdata_q[TCTRL_IE];
        auto_reload <= wdata_q[TCTRL_AUTO];
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (commit && ram_hit) begin
      if (be_q[0]) ram[ram_idx][7:0]        <= wdata_q[7:0];
      if (be_q[1]) ram[ram_idx][DATA_W-1:8] <= wdata_q[DATA_W-1:8];
    end
  end

  // Combinational read so the ACK cycle sees pre-write contents.
  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = ram[ram_idx];
    end else begin
      case (word_addr)
        ADDR_W'(LED_ADDR):    rdata = DATA_W'(led);
        ADDR_W'(TLOAD_ADDR):  rdata = tload;
        ADDR_W'(TCTRL_ADDR):  rdata = DATA_W'({auto_reload, ie, en});
        ADDR_W'(TSTAT_ADDR):  rdata = DATA_W'(exp_flag);
        ADDR_W'(TCOUNT_ADDR): rdata = tcount;
        default:              rdata = '0;
      endcase
    end
  end

  ext_bus_timer #(.DATA_W(DATA_W)) u_timer (
    .clk         (clk_clk),
    .rst_n       (reset_reset_n),
    .tctrl_wr    (tctrl_wr),
    .en_wdata    (wdata_q[TCTRL_EN]),
    .exp_clr     (exp_clr),
    .ie          (ie),
    .auto_reload (auto_reload),
    .tload       (tload),
    .tcount      (tcount),
    .exp_flag    (exp_flag),
    .en          (en),
    .irq         (irq)
  );

  assign acknowledge = (state == ST_ACK);
  assign read_data   = (state == ST_ACK) ? rdata : '0;
  assign ledr        = led;

endmodule
